// File: rtl/regfile_scoreboard.sv
// Register file with per-entry pending-write (busy) bits, same-cycle write bypass
// and a sequential clear engine that walks every entry once.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_busy_a,
    output logic              rd_busy_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    clr_state_e        state_q;
    logic [ADDR_W-1:0] idx_q;
    logic              clr_done_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;

    logic wr_ok_d;
    logic iss_ok_d;

    assign clr_busy = (state_q == CLEAR);
    assign clr_done = clr_done_q;

    // Qualify writeback/issue: blocked during clear and to the hardwired zero entry.
    always_comb begin
        wr_ok_d  = wr_en && !clr_busy && !(ZR && (wr_addr == '0));
        iss_ok_d = issue_en && !clr_busy && !(ZR && (issue_addr == '0));
    end

    // Read ports: zero entry first, then writeback bypass, then stored state.
    always_comb begin
        rd_data_a = mem_q[rd_addr_a];
        rd_busy_a = busy_q[rd_addr_a];
        if (ZR && (rd_addr_a == '0)) begin
            rd_data_a = '0;
            rd_busy_a = 1'b0;
        end else if (wr_en && !clr_busy && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
            rd_busy_a = 1'b0;
        end else begin
            rd_data_a = mem_q[rd_addr_a];
            rd_busy_a = busy_q[rd_addr_a];
        end

        rd_data_b = mem_q[rd_addr_b];
        rd_busy_b = busy_q[rd_addr_b];
        if (ZR && (rd_addr_b == '0)) begin
            rd_data_b = '0;
            rd_busy_b = 1'b0;
        end else if (wr_en && !clr_busy && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
            rd_busy_b = 1'b0;
        end else begin
            rd_data_b = mem_q[rd_addr_b];
            rd_busy_b = busy_q[rd_addr_b];
        end
    end

    // Storage and busy bits; the issue assignment comes last so it wins on a collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
        end else if (clr_busy) begin
            mem_q[idx_q]  <= '0;
            busy_q[idx_q] <= 1'b0;
        end else begin
            if (wr_ok_d) begin
                mem_q[wr_addr]  <= wr_data;
                busy_q[wr_addr] <= 1'b0;
            end
            if (iss_ok_d) begin
                busy_q[issue_addr] <= 1'b1;
            end
        end
    end

    // Clear engine: one entry per cycle, done pulse on the cycle after the last entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            clr_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    clr_done_q <= 1'b0;
                    if (clr_req) begin
                        state_q <= CLEAR;
                        idx_q   <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CLEAR: begin
                    idx_q <= idx_q + ADDR_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_q    <= IDLE;
                        clr_done_q <= 1'b1;
                    end else begin
                        state_q    <= CLEAR;
                        clr_done_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    idx_q      <= '0;
                    clr_done_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized and directed bench for regfile_scoreboard against an array-based model,
// plus a small 16x8 instance for the narrow configuration.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic [4:0]  rd_addr_a, rd_addr_b, wr_addr, issue_addr;
    logic [31:0] rd_data_a, rd_data_b, wr_data;
    logic        rd_busy_a, rd_busy_b, wr_en, issue_en, clr_req, clr_busy, clr_done;

    logic [2:0]  s_rd_addr_a, s_rd_addr_b, s_wr_addr, s_issue_addr;
    logic [15:0] s_rd_data_a, s_rd_data_b, s_wr_data;
    logic        s_rd_busy_a, s_rd_busy_b, s_wr_en, s_issue_en, s_clr_req, s_clr_busy, s_clr_done;

    regfile_scoreboard dut (
        .clk(clk), .reset(reset),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    regfile_scoreboard #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) dut_s (
        .clk(clk), .reset(reset),
        .rd_addr_a(s_rd_addr_a), .rd_addr_b(s_rd_addr_b),
        .rd_data_a(s_rd_data_a), .rd_data_b(s_rd_data_b),
        .rd_busy_a(s_rd_busy_a), .rd_busy_b(s_rd_busy_b),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .issue_en(s_issue_en), .issue_addr(s_issue_addr),
        .clr_req(s_clr_req), .clr_busy(s_clr_busy), .clr_done(s_clr_done)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: plain arrays plus a clear position (-1 when no clear is running).
    logic [31:0] m_mem [32];
    bit          m_busy [32];
    int          m_pos  = -1;
    bit          m_done = 1'b0;
    int          busy_cnt = 0;
    int          done_cnt = 0;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 32'd0;
            m_busy[i] = 1'b0;
        end
        m_pos  = -1;
        m_done = 1'b0;
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (m_pos < 0 && wr_en && wr_addr == a) return wr_data;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (m_pos < 0 && wr_en && wr_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic void model_edge();
        m_done = 1'b0;
        if (m_pos >= 0) begin
            m_mem[m_pos]  = 32'd0;
            m_busy[m_pos] = 1'b0;
            m_pos++;
            if (m_pos == 32) begin
                m_pos  = -1;
                m_done = 1'b1;
            end
        end else begin
            if (wr_en && wr_addr != 5'd0) begin
                m_mem[wr_addr]  = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (issue_en && issue_addr != 5'd0) m_busy[issue_addr] = 1'b1;
            if (clr_req) m_pos = 0;
        end
    endfunction

    // One clock: compare every output against the model mid-cycle, then advance both.
    task automatic step();
        @(negedge clk);
        check("rd_data_a", rd_data_a, exp_data(rd_addr_a));
        check("rd_data_b", rd_data_b, exp_data(rd_addr_b));
        check("rd_busy_a", rd_busy_a, exp_busy(rd_addr_a));
        check("rd_busy_b", rd_busy_b, exp_busy(rd_addr_b));
        check("clr_busy", clr_busy, m_pos >= 0);
        check("clr_done", clr_done, m_done);
        busy_cnt += int'(clr_busy);
        done_cnt += int'(clr_done);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; issue_en = 1'b0; clr_req = 1'b0;
        wr_addr = 5'd0; issue_addr = 5'd0; wr_data = 32'd0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        rd_addr_a = 5'd7; rd_addr_b = 5'd5;
        s_rd_addr_a = 3'd7; s_rd_addr_b = 3'd0; s_wr_en = 1'b0; s_wr_addr = 3'd0;
        s_wr_data = 16'd0; s_issue_en = 1'b0; s_issue_addr = 3'd0; s_clr_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_clr_busy", clr_busy, 1'b0);
        check("rst_clr_done", clr_done, 1'b0);
        check("rst_data", rd_data_a, 32'd0);
        reset = 1'b0;

        // Write then read back, then a same-cycle bypass.
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF;
        step();
        idle_inputs();
        #1 check("rd_after_wr", rd_data_a, 32'hDEADBEEF);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_1234;
        #1 check("bypass", rd_data_a, 32'h0000_1234);
        step();

        // Zero register.
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        issue_en = 1'b1; issue_addr = 5'd0; rd_addr_a = 5'd0;
        #1 check("zero_bypass", rd_data_a, 32'd0);
        step();
        idle_inputs();
        #1 check("zero_data", rd_data_a, 32'd0);
        check("zero_busy", rd_busy_a, 1'b0);

        // Busy tracking on entry 5.
        issue_en = 1'b1; issue_addr = 5'd5; rd_addr_b = 5'd5;
        step();
        idle_inputs();
        #1 check("busy_set", rd_busy_b, 1'b1);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h55;
        #1 check("busy_wb_same", rd_busy_b, 1'b0);
        step();
        idle_inputs();
        #1 check("busy_wb_after", rd_busy_b, 1'b0);
        step();
        issue_en = 1'b1; issue_addr = 5'd5; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h66;
        step();
        idle_inputs();
        #1 check("issue_wins", rd_busy_b, 1'b1);
        check("issue_wins_data", rd_data_b, 32'h66);

        // Fill 1..31, clear with writes attempted during the clear.
        for (int i = 1; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'h100 + 32'(i);
            issue_en = (i % 3 == 0); issue_addr = 5'(i);
            step();
        end
        idle_inputs();
        clr_req = 1'b1;
        step();
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            clr_req = 1'b0;
            wr_en = 1'b1; wr_addr = 5'($urandom_range(1, 31)); wr_data = $urandom;
            if (m_pos < 0) wr_en = 1'b0;
            step();
        end
        idle_inputs();
        check("clr_cycles", busy_cnt, 32);
        check("clr_done_cnt", done_cnt, 1);
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            #1 check("clr_zero", rd_data_a, 32'd0);
            check("clr_nobusy", rd_busy_a, 1'b0);
        end

        // Reset mid-clear at index 10.
        for (int i = 1; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'hA000 + 32'(i);
            step();
        end
        idle_inputs();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (10) step();
        rd_addr_a = 5'd20; rd_addr_b = 5'd30;
        #1 reset = 1'b1;
        #1 check("rst_mid_busy", clr_busy, 1'b0);
        check("rst_mid_data", rd_data_a, 32'd0);
        check("rst_mid_done", clr_done, 1'b0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        done_cnt = 0;
        repeat (30) step();
        check("rst_no_done", done_cnt, 0);

        // Randomized traffic, including back-to-back clears.
        for (int n = 0; n < 1500; n++) begin
            rd_addr_a = 5'($urandom); rd_addr_b = 5'($urandom);
            wr_en = ($urandom_range(0, 1) == 1); wr_addr = 5'($urandom); wr_data = $urandom;
            issue_en = ($urandom_range(0, 2) == 0); issue_addr = 5'($urandom);
            clr_req = ($urandom_range(0, 63) == 0) || (m_done && $urandom_range(0, 1) == 1);
            step();
        end
        idle_inputs();

        // Narrow instance: 8-entry clear and 16-bit data.
        s_wr_en = 1'b1; s_wr_addr = 3'd7; s_wr_data = 16'hABCD;
        @(posedge clk); #1;
        s_wr_en = 1'b0;
        #1 check("s_rd", s_rd_data_a, 16'hABCD);
        s_clr_req = 1'b1;
        @(posedge clk); #1;
        s_clr_req = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            busy_cnt += int'(s_clr_busy);
            done_cnt += int'(s_clr_done);
        end
        check("s_clr_cycles", busy_cnt, 8);
        check("s_clr_done", done_cnt, 1);
        check("s_rd_cleared", s_rd_data_a, 16'd0);
        check("s_zero", s_rd_data_b, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter ZERO_REG, default 1, entry 0 hardwired to zero and never busy when 1.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports rd_addr_a, rd_addr_b  input  ADDR_W  read port addresses.
REQ-007 SHALL have ports rd_data_a, rd_data_b  output  DATA_W  read data.
REQ-008 SHALL have ports rd_busy_a, rd_busy_b  output  1  addressed entry has a pending write.
REQ-009 SHALL have ports wr_en  input  1, wr_addr  input  ADDR_W, wr_data  input  DATA_W  writeback port.
REQ-010 SHALL have ports issue_en  input  1, issue_addr  input  ADDR_W  marks destination pending.
REQ-011 SHALL have port clr_req  input  1  request sequential clear of all entries.
REQ-012 SHALL have port clr_busy  output  1  clear engine active.
REQ-013 SHALL have port clr_done  output  1  one-cycle pulse at end of clear.

Function
REQ-014 SHALL read combinationally: rd_data_x = entry[rd_addr_x], except bypass below.
REQ-015 SHALL bypass: wr_en=1, wr_addr==rd_addr_x, clr_busy=0 -> rd_data_x = wr_data same cycle.
REQ-016 SHALL write wr_data to entry[wr_addr] at rising clk when wr_en=1 and clr_busy=0.
REQ-017 SHALL, with ZERO_REG=1, ignore writes/issues to address 0; reads of 0 return 0, no bypass, rd_busy 0.
REQ-018 SHALL hold busy bit per entry: set at rising clk when issue_en=1; cleared when wr_en=1 to that entry.
REQ-019 SHALL, on simultaneous issue and write to same address, leave busy set (new issue wins) while data is written.
REQ-020 SHALL drive rd_busy_x = busy[rd_addr_x] AND NOT (wr_en AND wr_addr==rd_addr_x AND clr_busy=0).
REQ-021 SHALL implement clear FSM states IDLE and CLEAR; IDLE + clr_req=1 at rising clk -> CLEAR, index=0.
REQ-022 SHALL in CLEAR write 0 to entry[index] and clear busy[index] each cycle, index+1, for DEPTH cycles.
REQ-023 SHALL, after entry DEPTH-1 is cleared, return to IDLE and assert clr_done for exactly one cycle.
REQ-024 SHALL assert clr_busy=1 exactly while state is CLEAR; clear of DEPTH entries takes DEPTH cycles.
REQ-025 SHALL ignore wr_en, issue_en and clr_req while clr_busy=1; reads stay live (partially cleared contents).
REQ-026 SHALL allow a new clr_req in the cycle clr_done is high (FSM already IDLE) to start another clear.
REQ-027 SHALL wrap index width ADDR_W without overflow beyond DEPTH-1.

Reset
REQ-028 SHALL on reset=1 immediately zero all entries and busy bits, FSM to IDLE, index 0, clr_busy=0, clr_done=0.
REQ-029 SHALL on reset asserted mid-clear abort the clear with no clr_done pulse.
REQ-030 SHALL after reset release accept write/issue on the first rising clk.

Verification
REQ-031 SHALL test write 0xDEADBEEF to 7, read next cycle on port a -> 0xDEADBEEF; same-cycle read of 7 during write of 0x1234 -> 0x1234 (bypass).
REQ-032 SHALL test write 0xFFFFFFFF to 0 with ZERO_REG=1 -> rd_data 0, rd_busy 0.
REQ-033 SHALL test issue 5, then rd_busy_b=1 at addr 5; writeback 5 -> rd_busy_b=0 that cycle and 0 thereafter; issue+write 5 same cycle -> busy stays 1.
REQ-034 SHALL test fill entries 1..31 nonzero, pulse clr_req -> clr_busy high 32 cycles, clr_done pulse once, all reads 0, wr_en during clear ignored.
REQ-035 SHALL test reset asserted at clear index 10 -> all entries 0, clr_busy 0 immediately, no clr_done.
REQ-036 SHALL test DATA_W=16, ADDR_W=3 instance: clear takes 8 cycles, write 0xABCD to 7 reads back 0xABCD.
